// File: rtl/cdb_arbiter_if.sv
// Bundles the handshake, control and broadcast signals of the CDB arbiter.
// Latency: none, this is wiring only.
// Backpressure: requesters see x_ready from the arbiter and must hold offers while it is low.
interface cdb_arbiter_if #(
    parameter int ROB_ID_W = 4
);
    logic                rdy;
    logic                clear;

    logic                alu_valid;
    logic [ROB_ID_W-1:0] alu_rob_id;
    logic [31:0]         alu_value;
    logic                alu_ready;

    logic                lsb_valid;
    logic [ROB_ID_W-1:0] lsb_rob_id;
    logic [31:0]         lsb_value;
    logic                lsb_ready;

    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [31:0]         cdb_value;
    logic                cdb_src;

    // Arbiter side
    modport slave (
        input  rdy, clear,
        input  alu_valid, alu_rob_id, alu_value,
        input  lsb_valid, lsb_rob_id, lsb_value,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_src
    );

    // Requester / consumer side
    modport master (
        output rdy, clear,
        output alu_valid, alu_rob_id, alu_value,
        output lsb_valid, lsb_rob_id, lsb_value,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Merges ALU and LSB results onto one common data bus through per-source FIFOs and round-robin.
// Latency: entry pushed at edge k is broadcast after edge k+1 at the earliest (no bypass).
// Backpressure: x_ready drops when that FIFO is full; rdy=0 freezes everything, clear flushes.
module cdb_arbiter #(
    parameter int ROB_ID_W = 4,
    parameter int DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [31:0]         value;
    } entry_t;

    entry_t              r_alu_mem [DEPTH];
    entry_t              r_lsb_mem [DEPTH];
    logic [PTR_W-1:0]    r_alu_wptr, r_alu_rptr;
    logic [PTR_W-1:0]    r_lsb_wptr, r_lsb_rptr;
    logic [CNT_W-1:0]    r_alu_cnt,  r_lsb_cnt;
    logic                r_last_grant;   // 0 = ALU, 1 = LSB
    logic                r_cdb_valid;
    logic [ROB_ID_W-1:0] r_cdb_rob_id;
    logic [31:0]         r_cdb_value;
    logic                r_cdb_src;

    logic   w_go;
    logic   w_alu_ready, w_lsb_ready;
    logic   w_alu_ne, w_lsb_ne;
    logic   w_grant_lsb;
    logic   w_alu_push, w_lsb_push;
    logic   w_alu_pop, w_lsb_pop;
    entry_t w_pop_entry;

    // Ready comes from registered counts only, so a same-cycle pop never frees a slot early.
    assign w_alu_ready = (r_alu_cnt != FULL_CNT);
    assign w_lsb_ready = (r_lsb_cnt != FULL_CNT);
    assign w_alu_ne    = (r_alu_cnt != '0);
    assign w_lsb_ne    = (r_lsb_cnt != '0);

    // Activity only when enabled and not flushing; a flush cycle discards offers.
    assign w_go        = bus.rdy & ~bus.clear;

    // LSB wins if it is the only non-empty FIFO, or on a tie when the ALU won last.
    assign w_grant_lsb = w_lsb_ne & (~w_alu_ne | ~r_last_grant);
    assign w_alu_pop   = w_go & w_alu_ne & ~w_grant_lsb;
    assign w_lsb_pop   = w_go & w_grant_lsb;
    assign w_alu_push  = w_go & bus.alu_valid & w_alu_ready;
    assign w_lsb_push  = w_go & bus.lsb_valid & w_lsb_ready;
    assign w_pop_entry = w_grant_lsb ? r_lsb_mem[r_lsb_rptr] : r_alu_mem[r_alu_rptr];

    // FIFO storage; contents need no reset because counts gate every read.
    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_alu_mem[r_alu_wptr] <= '{rob_id: bus.alu_rob_id, value: bus.alu_value};
        end
        if (w_lsb_push) begin
            r_lsb_mem[r_lsb_wptr] <= '{rob_id: bus.lsb_rob_id, value: bus.lsb_value};
        end
    end

    // ALU FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_wptr <= '0;
            r_alu_rptr <= '0;
            r_alu_cnt  <= '0;
        end else if (bus.rdy) begin
            if (bus.clear) begin
                r_alu_wptr <= '0;
                r_alu_rptr <= '0;
                r_alu_cnt  <= '0;
            end else begin
                if (w_alu_push) r_alu_wptr <= r_alu_wptr + PTR_W'(1);
                if (w_alu_pop)  r_alu_rptr <= r_alu_rptr + PTR_W'(1);
                case ({w_alu_push, w_alu_pop})
                    2'b10:   r_alu_cnt <= r_alu_cnt + CNT_W'(1);
                    2'b01:   r_alu_cnt <= r_alu_cnt - CNT_W'(1);
                    default: r_alu_cnt <= r_alu_cnt;
                endcase
            end
        end
    end

    // LSB FIFO pointers and occupancy, same scheme as the ALU side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lsb_wptr <= '0;
            r_lsb_rptr <= '0;
            r_lsb_cnt  <= '0;
        end else if (bus.rdy) begin
            if (bus.clear) begin
                r_lsb_wptr <= '0;
                r_lsb_rptr <= '0;
                r_lsb_cnt  <= '0;
            end else begin
                if (w_lsb_push) r_lsb_wptr <= r_lsb_wptr + PTR_W'(1);
                if (w_lsb_pop)  r_lsb_rptr <= r_lsb_rptr + PTR_W'(1);
                case ({w_lsb_push, w_lsb_pop})
                    2'b10:   r_lsb_cnt <= r_lsb_cnt + CNT_W'(1);
                    2'b01:   r_lsb_cnt <= r_lsb_cnt - CNT_W'(1);
                    default: r_lsb_cnt <= r_lsb_cnt;
                endcase
            end
        end
    end

    // Broadcast register and round-robin state; last_grant starts at LSB so ALU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_value  <= '0;
            r_cdb_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (bus.rdy) begin
            if (bus.clear) begin
                r_cdb_valid  <= 1'b0;
                r_last_grant <= 1'b1;
            end else if (w_alu_pop | w_lsb_pop) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_rob_id <= w_pop_entry.rob_id;
                r_cdb_value  <= w_pop_entry.value;
                r_cdb_src    <= w_grant_lsb;
                r_last_grant <= w_grant_lsb;
            end else begin
                r_cdb_valid  <= 1'b0;
            end
        end
    end

    assign bus.alu_ready  = w_alu_ready;
    assign bus.lsb_ready  = w_lsb_ready;
    assign bus.cdb_valid  = r_cdb_valid;
    assign bus.cdb_rob_id = r_cdb_rob_id;
    assign bus.cdb_value  = r_cdb_value;
    assign bus.cdb_src    = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, full FIFO, flush, stall, async reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ALU values are 0x100+id and LSB values 0x200+id so the value bus can be checked alongside ids.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    cdb_arbiter_if #(.ROB_ID_W(4)) bus ();

    cdb_arbiter #(.ROB_ID_W(4), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          q_alu_in[$];
    int          q_lsb_in[$];
    int          q_obs_id[$];
    int          q_obs_src[$];
    logic [31:0] q_obs_val[$];
    bit          alu_dip, lsb_dip, stream_timeout;
    int          lsb_refused;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input bit av, input int aid, input bit lv, input int lid);
        bus.alu_valid  = av;
        bus.alu_rob_id = 4'(aid);
        bus.alu_value  = 32'h100 + 32'(aid);
        bus.lsb_valid  = lv;
        bus.lsb_rob_id = 4'(lid);
        bus.lsb_value  = 32'h200 + 32'(lid);
    endtask

    task automatic do_reset();
        offer(0, 0, 0, 0);
        bus.rdy   = 1'b1;
        bus.clear = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // Drives both queues, holding each head offer until accepted; records every broadcast.
    task automatic run_streams(input int max_cycles);
        int idle;
        idle = 0;
        q_obs_id.delete();
        q_obs_src.delete();
        q_obs_val.delete();
        alu_dip = 0;
        lsb_dip = 0;
        lsb_refused = 0;
        stream_timeout = 1;
        for (int c = 0; c < max_cycles; c++) begin
            bit a_acc, l_acc;
            offer(q_alu_in.size() != 0, (q_alu_in.size() != 0) ? q_alu_in[0] : 0,
                  q_lsb_in.size() != 0, (q_lsb_in.size() != 0) ? q_lsb_in[0] : 0);
            a_acc = bus.alu_valid && bus.alu_ready;
            l_acc = bus.lsb_valid && bus.lsb_ready;
            if (bus.alu_valid && !bus.alu_ready) alu_dip = 1;
            if (bus.lsb_valid && !bus.lsb_ready) begin
                lsb_dip = 1;
                lsb_refused++;
            end
            tick();
            if (a_acc) void'(q_alu_in.pop_front());
            if (l_acc) void'(q_lsb_in.pop_front());
            if (bus.cdb_valid) begin
                q_obs_id.push_back(int'(bus.cdb_rob_id));
                q_obs_src.push_back(int'(bus.cdb_src));
                q_obs_val.push_back(bus.cdb_value);
                idle = 0;
            end else begin
                idle++;
            end
            if (q_alu_in.size() == 0 && q_lsb_in.size() == 0 && idle >= 2) begin
                stream_timeout = 0;
                break;
            end
        end
        offer(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        offer(0, 0, 0, 0);
        bus.rdy   = 1'b1;
        bus.clear = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_valid got=%0b exp=0", bus.cdb_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.cdb_rob_id !== 4'd0 || bus.cdb_value !== 32'd0 || bus.cdb_src !== 1'b0) begin
            failures++;
            $display("FAIL reset_cdb_fields got id=%0d val=%h src=%0b exp 0/0/0",
                     bus.cdb_rob_id, bus.cdb_value, bus.cdb_src);
        end
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got alu=%0b lsb=%0b exp 1/1", bus.alu_ready, bus.lsb_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cdb_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_valid cycle=%0d got=%0b exp=0", i, bus.cdb_valid);
            end
        end
    endtask

    task automatic test_single_push();
        do_reset();
        bus.alu_valid  = 1'b1;
        bus.alu_rob_id = 4'd3;
        bus.alu_value  = 32'h11;
        tick();
        offer(0, 0, 0, 0);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_no_bypass got valid=%0b exp=0", bus.cdb_valid);
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd3 ||
            bus.cdb_value !== 32'h11 || bus.cdb_src !== 1'b0) begin
            failures++;
            $display("FAIL single_broadcast got v=%0b id=%0d val=%h src=%0b exp 1/3/11/0",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.cdb_src);
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_id !== 4'd3 || bus.cdb_value !== 32'h11) begin
            failures++;
            $display("FAIL single_after got v=%0b id=%0d val=%h exp 0/3/11 (held)",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        end
    endtask

    task automatic test_round_robin();
        int exp_id[6]  = '{1, 9, 2, 10, 3, 11};
        int exp_src[6] = '{0, 1, 0, 1, 0, 1};
        do_reset();
        q_alu_in = '{1, 2, 3};
        q_lsb_in = '{9, 10, 11};
        run_streams(40);
        checks++;
        if (stream_timeout || q_obs_id.size() != 6) begin
            failures++;
            $display("FAIL rr_count got=%0d timeout=%0b exp=6", q_obs_id.size(), stream_timeout);
        end
        checks++;
        if (!(alu_dip || lsb_dip)) begin
            failures++;
            $display("FAIL rr_ready_dip got no dip exp at least one");
        end
        for (int i = 0; i < 6 && i < q_obs_id.size(); i++) begin
            checks++;
            if (q_obs_id[i] != exp_id[i] || q_obs_src[i] != exp_src[i] ||
                q_obs_val[i] !== ((exp_src[i] == 1 ? 32'h200 : 32'h100) + 32'(exp_id[i]))) begin
                failures++;
                $display("FAIL rr_order idx=%0d got id=%0d src=%0d val=%h exp id=%0d src=%0d",
                         i, q_obs_id[i], q_obs_src[i], q_obs_val[i], exp_id[i], exp_src[i]);
            end
        end
    endtask

    task automatic test_full_fifo();
        int exp_id[8] = '{1, 5, 2, 6, 3, 7, 4, 8};
        do_reset();
        q_alu_in = '{1, 2, 3, 4};
        q_lsb_in = '{5, 6, 7, 8};
        run_streams(50);
        checks++;
        if (!lsb_dip || lsb_refused == 0) begin
            failures++;
            $display("FAIL full_lsb_ready got dip=%0b refused=%0d exp dip=1 refused>0",
                     lsb_dip, lsb_refused);
        end
        checks++;
        if (stream_timeout || q_obs_id.size() != 8) begin
            failures++;
            $display("FAIL full_count got=%0d timeout=%0b exp=8", q_obs_id.size(), stream_timeout);
        end
        for (int i = 0; i < 8 && i < q_obs_id.size(); i++) begin
            checks++;
            if (q_obs_id[i] != exp_id[i]) begin
                failures++;
                $display("FAIL full_order idx=%0d got=%0d exp=%0d", i, q_obs_id[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        offer(1, 1, 1, 9);
        tick();
        offer(1, 2, 1, 10);
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd1) begin
            failures++;
            $display("FAIL flush_pre got v=%0b id=%0d exp 1/1", bus.cdb_valid, bus.cdb_rob_id);
        end
        bus.clear = 1'b1;
        offer(1, 3, 1, 11);
        tick();
        bus.clear = 1'b0;
        offer(0, 0, 0, 0);
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state got v=%0b alu_rdy=%0b lsb_rdy=%0b exp 0/1/1",
                     bus.cdb_valid, bus.alu_ready, bus.lsb_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cdb_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_leak cycle=%0d got v=%0b id=%0d exp v=0",
                         i, bus.cdb_valid, bus.cdb_rob_id);
            end
        end
        // Tie right after the flush must go to the ALU.
        offer(1, 5, 1, 12);
        tick();
        offer(0, 0, 0, 0);
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd5 ||
            bus.cdb_src !== 1'b0 || bus.cdb_value !== 32'h105) begin
            failures++;
            $display("FAIL flush_post_alu got v=%0b id=%0d src=%0b val=%h exp 1/5/0/105",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_value);
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd12 || bus.cdb_src !== 1'b1) begin
            failures++;
            $display("FAIL flush_post_lsb got v=%0b id=%0d src=%0b exp 1/12/1",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src);
        end
    endtask

    task automatic test_stall();
        int exp_id[3]  = '{9, 2, 10};
        int exp_src[3] = '{1, 0, 1};
        do_reset();
        offer(1, 1, 1, 9);
        tick();
        offer(1, 2, 1, 10);
        tick();
        // ALU FIFO holds 2, LSB FIFO holds 9,10; cdb shows id 1.
        bus.rdy = 1'b0;
        offer(1, 3, 1, 11);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd1 || bus.cdb_src !== 1'b0 ||
                bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_frozen cycle=%0d got v=%0b id=%0d src=%0b ar=%0b lr=%0b exp 1/1/0/1/0",
                         i, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.alu_ready, bus.lsb_ready);
            end
        end
        bus.rdy = 1'b1;
        offer(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'(exp_id[i]) ||
                bus.cdb_src !== 1'(exp_src[i])) begin
                failures++;
                $display("FAIL stall_resume idx=%0d got v=%0b id=%0d src=%0b exp 1/%0d/%0d",
                         i, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, exp_id[i], exp_src[i]);
            end
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_id !== 4'd10) begin
            failures++;
            $display("FAIL stall_drain got v=%0b id=%0d exp 0/10", bus.cdb_valid, bus.cdb_rob_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        offer(1, 4, 1, 13);
        tick();
        offer(0, 0, 0, 0);
        tick();
        // ALU id 4 is on the bus, LSB id 13 still buffered.
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_id !== 4'd0 || bus.cdb_value !== 32'd0 ||
            bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got v=%0b id=%0d val=%h ar=%0b lr=%0b exp 0/0/0/1/1",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cdb_valid !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_discard cycle=%0d got v=%0b id=%0d exp v=0",
                         i, bus.cdb_valid, bus.cdb_rob_id);
            end
        end
    endtask

    initial begin
        offer(0, 0, 0, 0);
        bus.rdy   = 1'b1;
        bus.clear = 1'b0;
        test_reset();
        test_single_push();
        test_round_robin();
        test_full_fifo();
        test_flush();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
